// File: rtl/matmem_pkg.sv
// ---------------------------------------------------------------------------
// matmem_pkg
// Shared definitions for the matrix memory bank:
//   - address layout: 16-bit address, module select in [15:12],
//     entry index in [11:0]
//   - default matrix geometry (element width, rows, columns, depth)
//   - state encoding of the power-up clear sequencer
// No ports (package).
// ---------------------------------------------------------------------------
package matmem_pkg;

  localparam int ADDR_W = 16;

  localparam int SEL_HI = 15;
  localparam int SEL_LO = 12;
  localparam int IDX_HI = 11;
  localparam int IDX_LO = 0;
  localparam int IDX_FIELD_W = IDX_HI - IDX_LO + 1;

  localparam int DEF_ELEM_W = 16;
  localparam int DEF_ROWS   = 4;
  localparam int DEF_COLS   = 4;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } initState_t;

endpackage

// File: rtl/matmem_init_seq.sv
// ---------------------------------------------------------------------------
// matmem_init_seq
// Power-up clear sequencer. After reset it walks every storage entry once,
// one entry per clock, asserting a write enable with the entry index, and
// then parks in IDLE until the next reset.
// Ports:
//   Clk      in   clock, rising edge
//   Reset    in   asynchronous, active-high reset (restarts the sweep)
//   Busy     out  high while the sweep is running (exactly DEPTH cycles)
//   clrIndex out  entry index being cleared this cycle
//   clrEn    out  write enable for the cleared entry
// ---------------------------------------------------------------------------
module matmem_init_seq
  import matmem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  output logic             Busy,
  output logic [IDX_W-1:0] clrIndex,
  output logic             clrEn
);

  initState_t       state;
  initState_t       nextState;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] nextIndex;

  // State and sweep counter. Reset always lands in CLEAR at entry 0 so an
  // interrupted sweep starts over from the beginning.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= CLEAR;
      index <= '0;
    end else begin
      state <= nextState;
      index <= nextIndex;
    end
  end

  // Sweep control: one entry per cycle while clearing, hand over to IDLE
  // on the last entry. IDLE never leaves on its own.
  always_comb begin
    nextState = state;
    nextIndex = index;
    Busy      = 1'b0;
    clrEn     = 1'b0;
    case (state)
      CLEAR: begin
        Busy  = 1'b1;
        clrEn = 1'b1;
        if (index == IDX_W'(DEPTH - 1)) begin
          nextState = IDLE;
        end else begin
          nextIndex = index + 1'b1;
        end
      end
      IDLE: begin
        nextState = IDLE;
      end
    endcase
  end

  assign clrIndex = index;

endmodule

// File: rtl/matrix_memory_bank.sv
// ---------------------------------------------------------------------------
// matrix_memory_bank
// Addressable store of DEPTH matrices (ROWS x COLS elements of ELEM_W bits)
// with per-element write masking, one-cycle registered reads and
// read-before-write behaviour for same-cycle read+write.
// Optional feature macro: MATMEM_PRELOAD_EN -- when defined, the power-up
// clear loads INIT0 into entry 0 and INIT1 into entry 1 instead of zero.
// Ports:
//   Clk      in   clock, rising edge
//   Reset    in   asynchronous, active-high reset
//   address  in   [15:12] module select, [11:0] entry index
//   nRead    in   active-low read strobe
//   nWrite   in   active-low write strobe
//   WrMask   in   per-element write enables (bit i -> element i)
//   DataIn   in   write data, element i at [i*ELEM_W +: ELEM_W]
//   DataOut  out  registered read data, held between reads
//   RdValid  out  one-cycle pulse when DataOut carries fresh read data
//   Busy     out  high while the power-up clear runs
//   AddrErr  out  one-cycle pulse on a selected access beyond DEPTH
// ---------------------------------------------------------------------------
module matrix_memory_bank
  import matmem_pkg::*;
#(
  parameter int                              ELEM_W    = DEF_ELEM_W,
  parameter int                              ROWS      = DEF_ROWS,
  parameter int                              COLS      = DEF_COLS,
  parameter int                              DEPTH     = DEF_DEPTH,
  parameter logic [3:0]                      MODULE_ID = 4'h0,
  parameter logic [ROWS*COLS*ELEM_W-1:0]     INIT0     = '0,
  parameter logic [ROWS*COLS*ELEM_W-1:0]     INIT1     = '0
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [ADDR_W-1:0]             address,
  input  logic                          nRead,
  input  logic                          nWrite,
  input  logic [ROWS*COLS-1:0]          WrMask,
  input  logic [ROWS*COLS*ELEM_W-1:0]   DataIn,
  output logic [ROWS*COLS*ELEM_W-1:0]   DataOut,
  output logic                          RdValid,
  output logic                          Busy,
  output logic                          AddrErr
);

  localparam int NUM_ELEM = ROWS * COLS;
  localparam int DATA_W   = NUM_ELEM * ELEM_W;
  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_FIELD_W:0] DEPTH_LIM = (IDX_FIELD_W + 1)'(DEPTH);

`ifdef MATMEM_PRELOAD_EN
  localparam bit PRELOAD_EN = 1'b1;
`else
  localparam bit PRELOAD_EN = 1'b0;
`endif

  logic [DATA_W-1:0]      mem [DEPTH];

  logic [IDX_W-1:0]       clrIndex;
  logic                   clrEn;
  logic [DATA_W-1:0]      clearData;

  logic [IDX_FIELD_W-1:0] reqIndex;
  logic [IDX_W-1:0]       memIndex;
  logic                   selected;
  logic                   accepted;
  logic                   inRange;
  logic                   doRead;
  logic                   doWrite;
  logic                   addrFault;

  matmem_init_seq #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) initSeq (
    .Clk      (Clk),
    .Reset    (Reset),
    .Busy     (Busy),
    .clrIndex (clrIndex),
    .clrEn    (clrEn)
  );

  // Access decode. The range test is done on the full 12-bit index field
  // so that out-of-range indices never alias onto a real entry through
  // the truncated storage index.
  always_comb begin
    reqIndex  = address[IDX_HI:IDX_LO];
    memIndex  = reqIndex[IDX_W-1:0];
    selected  = (address[SEL_HI:SEL_LO] == MODULE_ID);
    accepted  = selected && !Busy && (!nRead || !nWrite);
    inRange   = ({1'b0, reqIndex} < DEPTH_LIM);
    doRead    = accepted && inRange && !nRead;
    doWrite   = accepted && inRange && !nWrite;
    addrFault = accepted && !inRange;
  end

  // Image written by the clear sweep: zero everywhere, except the first
  // two entries when preloading is built in.
  always_comb begin
    clearData = '0;
    if (PRELOAD_EN && (clrIndex == IDX_W'(0))) begin
      clearData = INIT0;
    end else if (PRELOAD_EN && (clrIndex == IDX_W'(1))) begin
      clearData = INIT1;
    end
  end

  // Storage array. Deliberately not reset: its contents are defined only
  // by the clear sweep. Accesses are refused while Busy, so the sweep and
  // user writes never compete for the array.
  always_ff @(posedge Clk) begin
    if (clrEn) begin
      mem[clrIndex] <= clearData;
    end else if (doWrite) begin
      for (int e = 0; e < NUM_ELEM; e++) begin
        if (WrMask[e]) begin
          mem[memIndex][e*ELEM_W +: ELEM_W] <= DataIn[e*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  // Registered read path and status pulses. Sampling mem here in the same
  // edge as a write gives read-before-write for a same-index read+write.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      DataOut <= '0;
      RdValid <= 1'b0;
      AddrErr <= 1'b0;
    end else begin
      RdValid <= doRead;
      AddrErr <= addrFault;
      if (doRead) begin
        DataOut <= mem[memIndex];
      end
    end
  end

endmodule

// File: tb/tb_matrix_memory_bank.sv
// ---------------------------------------------------------------------------
// tb_matrix_memory_bank
// Directed self-checking bench for matrix_memory_bank with default geometry
// (16-bit elements, 4x4, 16 entries). Expected entries 0 and 1 follow the
// MATMEM_PRELOAD_EN build option.
// ---------------------------------------------------------------------------
module tb_matrix_memory_bank;

  localparam int DW = 256;

  localparam logic [DW-1:0] INIT0_V = 256'h3;
  localparam logic [DW-1:0] INIT1_V = {16{16'hC0DE}};

`ifdef MATMEM_PRELOAD_EN
  localparam logic [DW-1:0] EXP0 = INIT0_V;
  localparam logic [DW-1:0] EXP1 = INIT1_V;
`else
  localparam logic [DW-1:0] EXP0 = '0;
  localparam logic [DW-1:0] EXP1 = '0;
`endif

  logic          Clk;
  logic          Reset;
  logic [15:0]   address;
  logic          nRead;
  logic          nWrite;
  logic [15:0]   WrMask;
  logic [DW-1:0] DataIn;
  logic [DW-1:0] DataOut;
  logic          RdValid;
  logic          Busy;
  logic          AddrErr;

  int assertCount = 0;
  int failCount   = 0;

  matrix_memory_bank #(
    .ELEM_W    (16),
    .ROWS      (4),
    .COLS      (4),
    .DEPTH     (16),
    .MODULE_ID (4'h0),
    .INIT0     (INIT0_V),
    .INIT1     (INIT1_V)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .address (address),
    .nRead   (nRead),
    .nWrite  (nWrite),
    .WrMask  (WrMask),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .RdValid (RdValid),
    .Busy    (Busy),
    .AddrErr (AddrErr)
  );

  // 100 MHz clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Hard stop in case something upstream never returns
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DW-1:0] fillAll(input logic [15:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic nR, input logic nW,
                               input logic [15:0] m, input logic [DW-1:0] d);
    address = a;
    nRead   = nR;
    nWrite  = nW;
    WrMask  = m;
    DataIn  = d;
  endtask

  task automatic idle();
    applyStimulus(16'h0000, 1'b1, 1'b1, 16'h0000, '0);
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One-cycle read strobe, then back to idle inputs
  task automatic readEntry(input logic [15:0] a);
    applyStimulus(a, 1'b0, 1'b1, 16'h0000, '0);
    tick();
    idle();
  endtask

  // One-cycle write strobe, then back to idle inputs
  task automatic writeEntry(input logic [15:0] a, input logic [15:0] m, input logic [DW-1:0] d);
    applyStimulus(a, 1'b1, 1'b0, m, d);
    tick();
    idle();
  endtask

  // Counts clock edges until Busy drops, bounded; notes any status pulse
  task automatic countBusy(output int n, output bit sawPulse);
    n = 0;
    sawPulse = 1'b0;
    while (Busy && n < 100) begin
      tick();
      n++;
      if (RdValid || AddrErr) sawPulse = 1'b1;
    end
  endtask

  int            busyCycles;
  bit            sawPulse;
  logic [DW-1:0] exp4;

  initial begin
    Reset = 1'b1;
    idle();
    tick();
    tick();
    checkOutput("reset_busy",    DW'(Busy),    DW'(1'b1));
    checkOutput("reset_dataout", DataOut,      '0);
    checkOutput("reset_rdvalid", DW'(RdValid), DW'(1'b0));
    checkOutput("reset_addrerr", DW'(AddrErr), DW'(1'b0));

    Reset = 1'b0;
    countBusy(busyCycles, sawPulse);
    checkOutput("busy_len", DW'(busyCycles), DW'(16));
    checkOutput("busy_after", DW'(Busy), DW'(1'b0));

    readEntry(16'h0005);
    checkOutput("rd5_valid", DW'(RdValid), DW'(1'b1));
    checkOutput("rd5_data",  DataOut,      '0);
    tick();
    checkOutput("rd5_valid_drop", DW'(RdValid), DW'(1'b0));

    readEntry(16'h0000);
    checkOutput("rd0_data", DataOut, EXP0);
    readEntry(16'h0001);
    checkOutput("rd1_data", DataOut, EXP1);

    writeEntry(16'h0002, 16'h0001, fillAll(16'hFFFF));
    checkOutput("wr2_novalid", DW'(RdValid), DW'(1'b0));
    checkOutput("wr2_noerr",   DW'(AddrErr), DW'(1'b0));
    readEntry(16'h0002);
    checkOutput("rd2_valid", DW'(RdValid), DW'(1'b1));
    checkOutput("rd2_data",  DataOut,      {240'b0, 16'hFFFF});
    tick();
    checkOutput("rd2_hold", DataOut, {240'b0, 16'hFFFF});

    applyStimulus(16'h0003, 1'b0, 1'b0, 16'hFFFF, fillAll(16'h00AA));
    tick();
    idle();
    checkOutput("rbw_valid", DW'(RdValid), DW'(1'b1));
    checkOutput("rbw_old",   DataOut,      '0);
    readEntry(16'h0003);
    checkOutput("rbw_new", DataOut, fillAll(16'h00AA));

    writeEntry(16'h1002, 16'hFFFF, fillAll(16'h5555));
    checkOutput("unsel_wr_valid", DW'(RdValid), DW'(1'b0));
    checkOutput("unsel_wr_err",   DW'(AddrErr), DW'(1'b0));
    readEntry(16'h1002);
    checkOutput("unsel_rd_valid", DW'(RdValid), DW'(1'b0));
    checkOutput("unsel_rd_hold",  DataOut,      fillAll(16'h00AA));
    readEntry(16'h0002);
    checkOutput("unsel_nochange", DataOut, {240'b0, 16'hFFFF});

    writeEntry(16'h0010, 16'hFFFF, fillAll(16'h6666));
    checkOutput("oor_wr_err",   DW'(AddrErr), DW'(1'b1));
    checkOutput("oor_wr_valid", DW'(RdValid), DW'(1'b0));
    tick();
    checkOutput("oor_err_drop", DW'(AddrErr), DW'(1'b0));
    readEntry(16'h0010);
    checkOutput("oor_rd_err",   DW'(AddrErr), DW'(1'b1));
    checkOutput("oor_rd_valid", DW'(RdValid), DW'(1'b0));
    checkOutput("oor_rd_hold",  DataOut,      {240'b0, 16'hFFFF});
    readEntry(16'h0000);
    checkOutput("oor_nochange", DataOut, EXP0);

    // Sparse mask 0xA005: elements 0, 2, 13, 15 take element-i data 0x0100+i
    applyStimulus(16'h0004, 1'b1, 1'b0, 16'hA005, '0);
    for (int i = 0; i < 16; i++) DataIn[i*16 +: 16] = 16'h0100 + 16'(i);
    tick();
    idle();
    exp4 = '0;
    exp4[0   +: 16] = 16'h0100;
    exp4[32  +: 16] = 16'h0102;
    exp4[208 +: 16] = 16'h010D;
    exp4[240 +: 16] = 16'h010F;
    readEntry(16'h0004);
    checkOutput("sparse_mask", DataOut, exp4);

    writeEntry(16'h000F, 16'hFFFF, fillAll(16'h7777));
    readEntry(16'h000F);
    checkOutput("last_entry", DataOut, fillAll(16'h7777));

    // Asynchronous reset between edges, then abort a sweep part-way
    Reset = 1'b1;
    #1;
    checkOutput("arst_dataout", DataOut,      '0);
    checkOutput("arst_busy",    DW'(Busy),    DW'(1'b1));
    checkOutput("arst_valid",   DW'(RdValid), DW'(1'b0));
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checkOutput("midclr_busy", DW'(Busy), DW'(1'b1));
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    applyStimulus(16'h0005, 1'b0, 1'b0, 16'hFFFF, fillAll(16'h9999));
    countBusy(busyCycles, sawPulse);
    idle();
    checkOutput("busy_len2",    DW'(busyCycles), DW'(16));
    checkOutput("busy_ignored", DW'(sawPulse),   DW'(1'b0));

    readEntry(16'h0002);
    checkOutput("reclr_e2", DataOut, '0);
    readEntry(16'h0003);
    checkOutput("reclr_e3", DataOut, '0);
    readEntry(16'h0004);
    checkOutput("reclr_e4", DataOut, '0);
    readEntry(16'h000F);
    checkOutput("reclr_e15", DataOut, '0);
    readEntry(16'h0005);
    checkOutput("reclr_e5", DataOut, '0);
    readEntry(16'h0000);
    checkOutput("reclr_e0", DataOut, EXP0);
    readEntry(16'h0001);
    checkOutput("reclr_e1", DataOut, EXP1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
